cgra_pc_fetch: RTL and testbench

Program-counter register and instruction-fetch stage of the CGRA controller. It consumes the PC control strobes (`clken_PC`, `load_PC`, `incr_PC`, `load_value_PC`) produced by the PC next-state logic. It holds the architectural PC and reads a local instruction memory, presenting the instruction at the current PC to the decode stage with no bubble on sequential advance or taken branch. It also sequences program start and end-of-program detection.

---
 rtl/cgra_pc_fetch_if.sv | 39 +++
 rtl/cgra_pc_fetch.sv | 105 ++++++++++
 tb/tb_cgra_pc_fetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cgra_pc_fetch_if.sv
`default_nettype none
// ============================================================================
//  cgra_pc_fetch_if
//  Control, program-load and fetch-output bundle of the CGRA PC/fetch stage.
//  Rev 1.0
// ============================================================================
interface cgra_pc_fetch_if #(
   parameter int PC_WIDTH    = 12,
   parameter int INSTR_WIDTH = 32
);
   logic                   start;
   logic [PC_WIDTH-1:0]    start_pc;
   logic [PC_WIDTH-1:0]    prog_end;
   logic                   clken_PC;
   logic                   load_PC;
   logic                   incr_PC;
   logic [PC_WIDTH-1:0]    load_value_PC;
   logic                   imem_wr_en;
   logic [PC_WIDTH-1:0]    imem_wr_addr;
   logic [INSTR_WIDTH-1:0] imem_wr_data;
   logic [PC_WIDTH-1:0]    pc;
   logic [INSTR_WIDTH-1:0] instr;
   logic                   instr_valid;
   logic                   running;
   logic                   done;

   modport master (
      output start, start_pc, prog_end, clken_PC, load_PC, incr_PC, load_value_PC,
             imem_wr_en, imem_wr_addr, imem_wr_data,
      input  pc, instr, instr_valid, running, done
   );

   modport slave (
      input  start, start_pc, prog_end, clken_PC, load_PC, incr_PC, load_value_PC,
             imem_wr_en, imem_wr_addr, imem_wr_data,
      output pc, instr, instr_valid, running, done
   );
endinterface
`default_nettype wire

// File: rtl/cgra_pc_fetch.sv
`default_nettype none
// ============================================================================
//  cgra_pc_fetch
//  Architectural PC register, local instruction memory and start/end sequencing.
//  Rev 1.0
// ============================================================================
module cgra_pc_fetch #(
   parameter int PC_WIDTH    = 12,
   parameter int INSTR_WIDTH = 32
) (
   input  wire logic         axis_aclk,
   input  wire logic         axis_resetn,
   cgra_pc_fetch_if.slave    bus
);

   localparam int c_MEM_DEPTH = 1 << PC_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [PC_WIDTH-1:0]    r_pc;
   logic [PC_WIDTH-1:0]    w_pc_next;
   logic [PC_WIDTH-1:0]    r_prog_end;
   logic                   w_start_acc;
   logic                   w_rd_en;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [INSTR_WIDTH-1:0] r_mem [c_MEM_DEPTH];

   // Next-PC mux doubles as the memory read address, so instr tracks pc with no bubble.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_start_acc  = 1'b0;
      w_rd_en      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_start_acc  = 1'b1;
               w_rd_en      = 1'b1;
               w_state_next = S_RUN;
               w_pc_next    = bus.start_pc;
            end
         end
         S_RUN: begin
            if (bus.clken_PC) begin
               w_rd_en = 1'b1;
               if (bus.load_PC) begin
                  w_pc_next = bus.load_value_PC;
               end else if (bus.incr_PC) begin
                  if (r_pc == r_prog_end) begin
                     w_state_next = S_DONE;
                  end else begin
                     w_pc_next = r_pc + 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_prog_end <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (w_start_acc) begin
            r_prog_end <= bus.prog_end;
         end
      end
   end

   // Write and read live in separate processes; NBA ordering gives read-first behaviour.
   always_ff @(posedge axis_aclk) begin
      if (bus.imem_wr_en) begin
         r_mem[bus.imem_wr_addr] <= bus.imem_wr_data;
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_instr <= '0;
      end else if (w_rd_en) begin
         r_instr <= r_mem[w_pc_next];
      end
   end

   assign bus.pc          = r_pc;
   assign bus.instr       = r_instr;
   assign bus.instr_valid = (r_state == S_RUN);
   assign bus.running     = (r_state == S_RUN);
   assign bus.done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cgra_pc_fetch.sv
`default_nettype none
// ============================================================================
//  tb_cgra_pc_fetch
//  Directed self-checking bench for the CGRA PC/fetch stage.
//  Rev 1.0
// ============================================================================
module tb_cgra_pc_fetch;

   localparam int PC_WIDTH    = 12;
   localparam int INSTR_WIDTH = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   cgra_pc_fetch_if #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) bus ();

   cgra_pc_fetch #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) dut (
      .axis_aclk   (clk),
      .axis_resetn (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_run(input string tag, input logic [11:0] epc, input logic [31:0] einstr);
      check({tag, ".pc"},    32'(bus.pc), 32'(epc));
      check({tag, ".instr"}, bus.instr, einstr);
      check({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
   endtask

   task automatic chk_done(input string tag, input logic [11:0] epc);
      check({tag, ".done"},    32'(bus.done), 32'd1);
      check({tag, ".running"}, 32'(bus.running), 32'd0);
      check({tag, ".valid"},   32'(bus.instr_valid), 32'd0);
      check({tag, ".pc"},      32'(bus.pc), 32'(epc));
   endtask

   task automatic do_start(input logic [11:0] spc, input logic [11:0] pend);
      bus.start_pc = spc;
      bus.prog_end = pend;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   initial begin
      bus.start = 0; bus.start_pc = '0; bus.prog_end = '0;
      bus.clken_PC = 0; bus.load_PC = 0; bus.incr_PC = 0; bus.load_value_PC = '0;
      bus.imem_wr_en = 0; bus.imem_wr_addr = '0; bus.imem_wr_data = '0;

      #12;
      check("rst.pc",      32'(bus.pc), 32'd0);
      check("rst.instr",   bus.instr, 32'd0);
      check("rst.valid",   32'(bus.instr_valid), 32'd0);
      check("rst.running", 32'(bus.running), 32'd0);
      check("rst.done",    32'(bus.done), 32'd0);
      rst_n = 1'b1;
      tick();

      // Program load: 0..7 and the top address used by the wrap test.
      for (int a = 0; a < 8; a++) begin
         bus.imem_wr_en   = 1'b1;
         bus.imem_wr_addr = 12'(a);
         bus.imem_wr_data = 32'hA000_0000 + 32'(a);
         tick();
      end
      bus.imem_wr_addr = 12'hFFF;
      bus.imem_wr_data = 32'hB000_0FFF;
      tick();
      bus.imem_wr_en = 1'b0;
      check("idle.running", 32'(bus.running), 32'd0);

      // Straight-line run 0..7.
      bus.clken_PC = 1'b1;
      bus.incr_PC  = 1'b1;
      do_start(12'h000, 12'h007);
      check("seq.running", 32'(bus.running), 32'd1);
      for (int i = 0; i < 8; i++) begin
         chk_run($sformatf("seq%0d", i), 12'(i), 32'hA000_0000 + 32'(i));
         tick();
      end
      chk_done("seq.end", 12'h007);
      tick();
      tick();
      chk_done("seq.hold", 12'h007);

      // Taken branch with load and incr both high; restart from DONE.
      do_start(12'h000, 12'h007);
      tick(); tick(); tick();
      chk_run("br.pre", 12'h003, 32'hA000_0003);
      bus.load_PC       = 1'b1;
      bus.load_value_PC = 12'h005;
      tick();
      bus.load_PC = 1'b0;
      chk_run("br.tgt", 12'h005, 32'hA000_0005);

      // Start during RUN is ignored.
      bus.start_pc = 12'h000;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      chk_run("ign.start", 12'h006, 32'hA000_0006);

      // Branch to 2, then hold with clken low.
      bus.load_PC       = 1'b1;
      bus.load_value_PC = 12'h002;
      tick();
      bus.load_PC  = 1'b0;
      bus.clken_PC = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_run($sformatf("hold%0d", i), 12'h002, 32'hA000_0002);
      end
      bus.clken_PC = 1'b1;
      tick();
      chk_run("hold.rel", 12'h003, 32'hA000_0003);

      // Loading the prog_end address is not an end condition.
      bus.load_PC       = 1'b1;
      bus.load_value_PC = 12'h007;
      tick();
      bus.load_PC = 1'b0;
      chk_run("ldend", 12'h007, 32'hA000_0007);
      check("ldend.done", 32'(bus.done), 32'd0);
      tick();
      chk_done("ldend.fin", 12'h007);

      // Wrap from all-ones to zero.
      do_start(12'hFFF, 12'h001);
      chk_run("wrap0", 12'hFFF, 32'hB000_0FFF);
      tick();
      chk_run("wrap1", 12'h000, 32'hA000_0000);
      tick();
      chk_run("wrap2", 12'h001, 32'hA000_0001);
      tick();
      chk_done("wrap.end", 12'h001);

      // Read-first collision on address 4.
      do_start(12'h003, 12'h007);
      chk_run("rf.pre", 12'h003, 32'hA000_0003);
      bus.imem_wr_en   = 1'b1;
      bus.imem_wr_addr = 12'h004;
      bus.imem_wr_data = 32'h1234_5678;
      tick();
      bus.imem_wr_en = 1'b0;
      chk_run("rf.old", 12'h004, 32'hA000_0004);
      bus.load_PC       = 1'b1;
      bus.load_value_PC = 12'h004;
      tick();
      bus.load_PC = 1'b0;
      chk_run("rf.new", 12'h004, 32'h1234_5678);

      // Asynchronous reset mid-run at pc=6.
      tick();
      tick();
      chk_run("ar.pre", 12'h006, 32'hA000_0006);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar.pc",      32'(bus.pc), 32'd0);
      check("ar.instr",   bus.instr, 32'd0);
      check("ar.valid",   32'(bus.instr_valid), 32'd0);
      check("ar.running", 32'(bus.running), 32'd0);
      check("ar.done",    32'(bus.done), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      check("ar.idle", 32'(bus.running), 32'd0);
      do_start(12'h000, 12'h007);
      chk_run("ar.start", 12'h000, 32'hA000_0000);
      do_start(12'h005, 12'h007);
      chk_run("ar.ign", 12'h001, 32'hA000_0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
